shape_sequencer: RTL and testbench
==================================

SHAPE_SEQUENCER -- requirements
Module: shape_sequencer

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000000: RUN length per shape in auto mode, in sysclk cycles; legal range is at least 2.
REQ-002 Parameter BLANK_CYCLES, default 1000: all-off gap between shapes, in cycles; legal range is at least 1.
REQ-003 Parameter DEB_CYCLES, default 500000: switch stability window, in cycles; used only when the debounce macro is defined.
REQ-004 Port sysclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port sw_in, input, 4 bits: raw one-hot shape request; bit0 Circle, bit1 Eight, bit2 Square, bit3 Solidsquare.
REQ-007 Port auto_en, input, 1 bit: 1 means cycle shapes automatically; 0 means follow sw_in.
REQ-008 Port enable_sw, output, 4 bits: one-hot or all-zero enable to the shape pulse generator.
REQ-009 Port shape_idx, output, 2 bits: index of the current or pending shape, 0 to 3.
REQ-010 Port blanking, output, 1 bit: high while the FSM is in BLANK.
REQ-011 Port shape_change, output, 1 bit: one-cycle pulse on the first RUN cycle of a shape.

Function
REQ-012 The FSM has three states: IDLE, BLANK and RUN; all outputs are registered.
REQ-013 enable_sw is 4'b0000 in IDLE and BLANK, and (1 << shape_idx) in RUN; no other value ever appears.
REQ-014 Manual request decode (auto_en=0), from the filtered sw_in:
- exactly one bit set: request idx = position of that bit;
- zero bits set: request off;
- two or more bits set: invalid; state and shape_idx are held.
REQ-015 IDLE: on a valid request, load shape_idx and go to BLANK; when auto_en=1, go to BLANK with the current shape_idx.
REQ-016 BLANK: the counter runs from 0 to BLANK_CYCLES-1, then goes to RUN; shape_change=1 on the first RUN cycle.
REQ-017 RUN, manual mode:
- a valid request different from shape_idx loads the new idx and goes to BLANK on the next cycle;
- an off request goes to IDLE;
- the same request or an invalid request holds.
REQ-018 RUN, auto mode: the dwell counter runs from 0 to DWELL_CYCLES-1; at terminal count shape_idx <= shape_idx+1 (mod 4, so 3 wraps to 0) and the FSM goes to BLANK.
REQ-019 A manual request arriving during BLANK updates shape_idx and restarts the BLANK counter; the gap is never shortened.
REQ-020 auto_en toggling in RUN clears the dwell counter and does not change the shape; auto_en 1->0 then applies REQ-017 from the next cycle.
REQ-021 Simultaneous events: the dwell terminal count and auto_en falling in the same cycle resolve in favour of manual; no increment occurs.
REQ-022 Each counter is sized $clog2 of its parameter; counters never wrap past their terminal count.

Reset
REQ-023 While rst is asserted: state=BLANK, shape_idx=0, enable_sw=0, blanking=1, shape_change=0, and all counters=0.
REQ-024 After release, one full BLANK gap runs before the first RUN.
REQ-025 Reset asserted mid-RUN forces enable_sw to 0 asynchronously.

Configuration
REQ-026 Macro SHAPE_SEQ_DEBOUNCE_EN controls input filtering.
- Defined: sw_in passes a two-flop synchroniser plus a DEB_CYCLES stability filter before decode, adding DEB_CYCLES+2 cycles of latency.
- Undefined: sw_in passes a two-flop synchroniser only, with 2 cycles of latency; DEB_CYCLES is ignored.

Structure
REQ-027 A shared package holds:
- state encoding constants IDLE=2'd0, BLANK=2'd1, RUN=2'd2;
- shape index constants CIRCLE=0, EIGHT=1, SQUARE=2, SOLIDSQUARE=3.
REQ-028 The sub-module sw_debounce (4-bit synchroniser and filter) is instantiated only under SHAPE_SEQ_DEBOUNCE_EN.

Verification
Bench parameters for all scenarios: DWELL=8, BLANK=3, DEB=4.
REQ-029 Reset release with auto_en=1: enable_sw=0 for 3 cycles, then 0001 with shape_change pulsing for 1 cycle, then 0001 held for 8 cycles.
REQ-030 Auto mode over 4 dwells: the enable_sw sequence is 0001, 0010, 0100, 1000, 0001 (wrap), with exactly 3 zero cycles between each pair.
REQ-031 Manual mode: sw_in=0100 while RUN shows 0001 -> 3 zero cycles, then enable_sw=0100; then sw_in=0110 -> enable_sw stays 0100 indefinitely.
REQ-032 Manual mode: sw_in=0000 in RUN -> IDLE, enable_sw=0; then sw_in=1000 -> BLANK for 3 cycles, then enable_sw=1000.
REQ-033 Change during BLANK: sw_in changes from 0010 to 1000 at the 2nd BLANK cycle -> the BLANK counter restarts, giving 4 or more zero cycles in total, then enable_sw=1000.
REQ-034 Reset mid-RUN: rst pulsed while enable_sw=0100 -> enable_sw=0 in the same cycle and shape_idx=0; with the debounce macro defined, a 2-cycle sw_in glitch causes no transition.

Source files
------------

// File: rtl/shape_sequencer_pkg.sv
// Shared definitions for the shape sequencer: FSM state codes, shape
// indices, switch-request decode and counter sizing helpers.
package shape_sequencer_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  // Shape indices (bit position in sw_in / enable_sw)
  localparam logic [1:0] CIRCLE      = 2'd0;
  localparam logic [1:0] EIGHT       = 2'd1;
  localparam logic [1:0] SQUARE      = 2'd2;
  localparam logic [1:0] SOLIDSQUARE = 2'd3;

  // Decoded manual request: one = exactly one switch set, off = none set.
  // Neither flag set means two or more switches: an invalid request.
  typedef struct packed {
    logic       one;
    logic       off;
    logic [1:0] idx;
  } sw_req_t;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic sw_req_t decode_req(input logic [3:0] sw);
    sw_req_t r;
    r.one = 1'b1;
    r.off = 1'b0;
    r.idx = CIRCLE;
    case (sw)
      4'b0000: begin
        r.one = 1'b0;
        r.off = 1'b1;
      end
      4'b0001: r.idx = CIRCLE;
      4'b0010: r.idx = EIGHT;
      4'b0100: r.idx = SQUARE;
      4'b1000: r.idx = SOLIDSQUARE;
      default: r.one = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] shape_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/shape_sequencer_sw_debounce.sv
// sw_debounce: two-flop synchroniser followed by a stability filter.
// The filtered output only takes a new value once the synchronised input
// has differed from it for DEB_CYCLES consecutive cycles; shorter glitches
// clear the count and are dropped.
module sw_debounce
  import shape_sequencer_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [3:0] sw_in,
  output logic [3:0] sw_out
);

  localparam int unsigned CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [3:0]    sync1_reg;
  logic [3:0]    sync2_reg;
  logic [3:0]    stable_reg;
  logic [CW-1:0] cnt_reg;

  // Bring the asynchronous switches into the sysclk domain
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sw_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Accept a new switch pattern only after it has persisted long enough
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      stable_reg <= '0;
      cnt_reg    <= '0;
    end else if (sync2_reg == stable_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      stable_reg <= sync2_reg;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign sw_out = stable_reg;

endmodule

// File: rtl/shape_sequencer.sv
// shape_sequencer: selects which shape generator is enabled, with an
// all-off blanking gap between shapes. Manual mode follows one-hot
// switches; auto mode steps through the four shapes on a dwell timer.
// Build option: define SHAPE_SEQ_DEBOUNCE_EN to add the sw_debounce
// stability filter after the input synchroniser.
module shape_sequencer
  import shape_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned DEB_CYCLES   = 500000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [3:0] sw_in,
  input  logic       auto_en,
  output logic [3:0] enable_sw,
  output logic [1:0] shape_idx,
  output logic       blanking,
  output logic       shape_change
);

  localparam int unsigned BW = cnt_width(BLANK_CYCLES);
  localparam int unsigned DW = cnt_width(DWELL_CYCLES);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (DWELL_CYCLES < 2) begin : g_bad_dwell
    $error("shape_sequencer: DWELL_CYCLES must be at least 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("shape_sequencer: BLANK_CYCLES must be at least 1");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("shape_sequencer: DEB_CYCLES must be at least 1");
  end

  logic [3:0] sw_filt;

`ifdef SHAPE_SEQ_DEBOUNCE_EN
  sw_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sw_debounce (
    .sysclk(sysclk),
    .rst   (rst),
    .sw_in (sw_in),
    .sw_out(sw_filt)
  );
`else
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;

  // Two-flop synchroniser only; the switches feed the decode directly
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sw_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign sw_filt = sync2_reg;
`endif

  sw_req_t req;
  assign req = decode_req(sw_filt);

  logic [1:0]    state_reg, state_next;
  logic [1:0]    idx_reg, idx_next;
  logic [BW-1:0] blank_cnt_reg, blank_cnt_next;
  logic [DW-1:0] dwell_cnt_reg, dwell_cnt_next;
  logic          auto_prev_reg;
  logic [3:0]    enable_sw_reg;
  logic          blanking_reg;
  logic          shape_change_reg;

  // Next-state, shape index and counter decisions
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    blank_cnt_next = blank_cnt_reg;
    dwell_cnt_next = dwell_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (auto_en) begin
          state_next     = BLANK;
          blank_cnt_next = '0;
        end else if (req.one) begin
          idx_next       = req.idx;
          state_next     = BLANK;
          blank_cnt_next = '0;
        end
      end
      BLANK: begin
        if (!auto_en && req.off) begin
          // Switches released before the shape appeared: abandon it
          state_next     = IDLE;
          blank_cnt_next = '0;
        end else if (!auto_en && req.one && (req.idx != idx_reg)) begin
          // New choice mid-gap: take it and start the gap over
          idx_next       = req.idx;
          blank_cnt_next = '0;
        end else if (blank_cnt_reg == BLANK_LAST) begin
          state_next     = RUN;
          blank_cnt_next = '0;
          dwell_cnt_next = '0;
        end else begin
          blank_cnt_next = blank_cnt_reg + BW'(1);
        end
      end
      RUN: begin
        if (auto_en != auto_prev_reg) begin
          // Mode change wins over everything else this cycle, including
          // a dwell terminal count, so no shape step can slip through
          dwell_cnt_next = '0;
        end else if (auto_en) begin
          if (dwell_cnt_reg == DWELL_LAST) begin
            idx_next       = idx_reg + 2'd1;
            state_next     = BLANK;
            blank_cnt_next = '0;
            dwell_cnt_next = '0;
          end else begin
            dwell_cnt_next = dwell_cnt_reg + DW'(1);
          end
        end else if (req.off) begin
          state_next = IDLE;
        end else if (req.one && (req.idx != idx_reg)) begin
          idx_next       = req.idx;
          state_next     = BLANK;
          blank_cnt_next = '0;
        end
      end
      default: begin
        state_next     = BLANK;
        blank_cnt_next = '0;
        dwell_cnt_next = '0;
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_reg        <= BLANK;
      idx_reg          <= CIRCLE;
      blank_cnt_reg    <= '0;
      dwell_cnt_reg    <= '0;
      auto_prev_reg    <= 1'b0;
      enable_sw_reg    <= 4'b0000;
      blanking_reg     <= 1'b1;
      shape_change_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      blank_cnt_reg    <= blank_cnt_next;
      dwell_cnt_reg    <= dwell_cnt_next;
      auto_prev_reg    <= auto_en;
      enable_sw_reg    <= (state_next == RUN) ? shape_onehot(idx_next) : 4'b0000;
      blanking_reg     <= (state_next == BLANK);
      shape_change_reg <= (state_next == RUN) && (state_reg != RUN);
    end
  end

  assign enable_sw    = enable_sw_reg;
  assign shape_idx    = idx_reg;
  assign blanking     = blanking_reg;
  assign shape_change = shape_change_reg;

endmodule

// File: tb/tb_shape_sequencer.sv
// Self-checking bench for shape_sequencer with DWELL=8, BLANK=3, DEB=4.
// A phase/countdown model predicts the outputs every cycle; literal
// expectations at chosen cycles pin the model itself.
module tb_shape_sequencer;

  localparam int DWELL = 8;
  localparam int BLANK = 3;
  localparam int DEB   = 4;
`ifdef SHAPE_SEQ_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_in = 4'b0000;
  logic       auto_en = 1'b0;
  logic [3:0] enable_sw;
  logic [1:0] shape_idx;
  logic       blanking;
  logic       shape_change;

  int tests = 0;
  int fails = 0;

  shape_sequencer #(
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK),
    .DEB_CYCLES  (DEB)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .sw_in       (sw_in),
    .auto_en     (auto_en),
    .enable_sw   (enable_sw),
    .shape_idx   (shape_idx),
    .blanking    (blanking),
    .shape_change(shape_change)
  );

  always #5 sysclk = ~sysclk;

  // ---------------- behavioural model ----------------
  typedef enum int {OFF, GAP, SHOW} phase_t;
  phase_t     m_phase;
  int         m_gap_left;
  int         m_shown;
  int         m_shape;
  bit         m_new;
  bit         m_auto_last;
  logic [3:0] m_pipe0, m_pipe1, m_filt;
  int         m_run;

  logic [3:0] tr_en[$];
  logic       tr_ch[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase     = GAP;
    m_gap_left  = BLANK;
    m_shown     = 0;
    m_shape     = 0;
    m_new       = 1'b0;
    m_auto_last = 1'b0;
    m_pipe0     = 4'b0;
    m_pipe1     = 4'b0;
    m_filt      = 4'b0;
    m_run       = 0;
  endtask

  // One clock edge of the intended behaviour, given the inputs at that edge
  task automatic model_step(input logic [3:0] sw, input logic au);
    logic [3:0] req;
    int ones, pos;
    req = m_pipe1;
    if (DEB_ON) begin
      req = m_filt;
      if (m_pipe1 != m_filt) begin
        m_run++;
        if (m_run == DEB) begin
          m_filt = m_pipe1;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    m_pipe1 = m_pipe0;
    m_pipe0 = sw;
    ones = $countones(req);
    pos = 0;
    for (int b = 0; b < 4; b++) if (req[b]) pos = b;
    m_new = 1'b0;
    case (m_phase)
      OFF: begin
        if (au) begin
          m_phase = GAP; m_gap_left = BLANK;
        end else if (ones == 1) begin
          m_shape = pos; m_phase = GAP; m_gap_left = BLANK;
        end
      end
      GAP: begin
        if (!au && ones == 0) begin
          m_phase = OFF;
        end else if (!au && ones == 1 && pos != m_shape) begin
          m_shape = pos; m_gap_left = BLANK;
        end else begin
          m_gap_left--;
          if (m_gap_left == 0) begin
            m_phase = SHOW; m_shown = 0; m_new = 1'b1;
          end
        end
      end
      default: begin
        if (au != m_auto_last) begin
          m_shown = 0;
        end else if (au) begin
          m_shown++;
          if (m_shown == DWELL) begin
            m_shape = (m_shape + 1) % 4; m_phase = GAP; m_gap_left = BLANK;
          end
        end else if (ones == 0) begin
          m_phase = OFF;
        end else if (ones == 1 && pos != m_shape) begin
          m_shape = pos; m_phase = GAP; m_gap_left = BLANK;
        end
      end
    endcase
    m_auto_last = au;
  endtask

  task automatic compare_model();
    logic [3:0] exp_en;
    exp_en = (m_phase == SHOW) ? (4'b0001 << m_shape) : 4'b0000;
    check("model_enable_sw", enable_sw, exp_en);
    check("model_shape_idx", shape_idx, m_shape);
    check("model_blanking", blanking, m_phase == GAP);
    check("model_shape_change", shape_change, m_new);
    tr_en.push_back(enable_sw);
    tr_ch.push_back(shape_change);
    $display("[TB] t=%0t sw=%b auto=%b en=%b idx=%0d blank=%b chg=%b",
             $time, sw_in, auto_en, enable_sw, shape_idx, blanking, shape_change);
  endtask

  // Drive inputs, advance one clock, step the model, compare on the falling edge
  task automatic tick(input logic [3:0] sw, input logic au);
    sw_in   = sw;
    auto_en = au;
    @(posedge sysclk);
    model_step(sw, au);
    @(negedge sysclk);
    compare_model();
  endtask

  task automatic ticks(input int n, input logic [3:0] sw, input logic au);
    for (int i = 0; i < n; i++) tick(sw, au);
  endtask

  initial begin
    int k, found;

    // ---- reset with auto_en=1 ----
    rst = 1'b1; auto_en = 1'b1; sw_in = 4'b0001;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      check("rst_enable_sw", enable_sw, 4'b0000);
      check("rst_blanking", blanking, 1'b1);
      check("rst_shape_idx", shape_idx, 2'd0);
      check("rst_shape_change", shape_change, 1'b0);
    end
    rst = 1'b0;
    #1;
    tr_en.delete(); tr_ch.delete();
    compare_model();
    ticks(48, 4'b0001, 1'b1);

    // first shape after release: 3 blank cycles, pulse, 8 cycles shown
    for (int i = 0; i < 3; i++) check("first_gap", tr_en[i], 4'b0000);
    check("first_run_en", tr_en[3], 4'b0001);
    check("first_run_pulse", tr_ch[3], 1'b1);
    check("first_run_pulse_len", tr_ch[4], 1'b0);
    check("first_run_last", tr_en[10], 4'b0001);
    check("first_run_end", tr_en[11], 4'b0000);
    // auto sequence 0001,0010,0100,1000,0001 with 3-cycle gaps
    for (k = 1; k <= 4; k++) begin
      check("auto_prev_shape", tr_en[11*k-1], 4'b0001 << ((k-1) % 4));
      for (int z = 0; z < 3; z++) check("auto_gap", tr_en[11*k+z], 4'b0000);
      check("auto_next_shape", tr_en[11*k+3], 4'b0001 << (k % 4));
    end

    // ---- manual mode: switch to SQUARE, then an invalid pattern ----
    ticks(4, 4'b0001, 1'b0);
    tr_en.delete(); tr_ch.delete();
    ticks(6, 4'b0100, 1'b0);
    check("man_sq_hold1", tr_en[0], 4'b0001);
    check("man_sq_hold2", tr_en[1], 4'b0001);
    for (int i = 2; i < 5; i++) check("man_sq_gap", tr_en[i], 4'b0000);
    check("man_sq_run", tr_en[5], 4'b0100);
    check("man_sq_pulse", tr_ch[5], 1'b1);
    ticks(10, 4'b0110, 1'b0);
    check("invalid_hold_en", enable_sw, 4'b0100);
    check("invalid_hold_idx", shape_idx, 2'd2);

    // ---- manual off -> IDLE, then SOLIDSQUARE ----
    tr_en.delete(); tr_ch.delete();
    ticks(6, 4'b0000, 1'b0);
    check("off_en", tr_en[2], 4'b0000);
    check("off_idle_en", enable_sw, 4'b0000);
    check("off_idle_blank", blanking, 1'b0);
    tr_en.delete(); tr_ch.delete();
    ticks(6, 4'b1000, 1'b0);
    check("idle_stay", tr_en[1], 4'b0000);
    for (int i = 2; i < 5; i++) check("idle_gap", tr_en[i], 4'b0000);
    check("idle_to_run", tr_en[5], 4'b1000);

    // ---- change during BLANK restarts the gap ----
    tr_en.delete(); tr_ch.delete();
    tick(4'b0010, 1'b0);
    tick(4'b1000, 1'b0);
    tick(4'b1000, 1'b0);
    check("blank_pending_idx", shape_idx, 2'd1);
    check("blank_pending_blank", blanking, 1'b1);
    tick(4'b1000, 1'b0);
    check("blank_restart_idx", shape_idx, 2'd3);
    ticks(3, 4'b1000, 1'b0);
    for (int i = 2; i < 6; i++) check("blank_restart_gap", tr_en[i], 4'b0000);
    check("blank_restart_run", tr_en[6], 4'b1000);

    // ---- reset mid-RUN ----
    ticks(6, 4'b0100, 1'b0);
    check("pre_reset_en", enable_sw, 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("async_rst_en", enable_sw, 4'b0000);
    check("async_rst_idx", shape_idx, 2'd0);
    check("async_rst_blank", blanking, 1'b1);
    model_reset();
    sw_in = 4'b0001; auto_en = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
    #1;
    compare_model();

    // ---- dwell terminal count coinciding with auto_en falling ----
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      tick(4'b0001, 1'b1);
      if (shape_change === 1'b1) found = i;
    end
    check("post_rst_gap_len", found, 3);
    ticks(7, 4'b0001, 1'b1);
    tick(4'b0001, 1'b0);
    check("tc_vs_manual_en", enable_sw, 4'b0001);
    check("tc_vs_manual_idx", shape_idx, 2'd0);
    check("tc_vs_manual_blank", blanking, 1'b0);
    ticks(4, 4'b0001, 1'b0);
    check("manual_after_tc", enable_sw, 4'b0001);

    if (DEB_ON) begin
      // a 2-cycle glitch is shorter than the stability window
      ticks(2, 4'b0100, 1'b0);
      ticks(12, 4'b0001, 1'b0);
      check("glitch_ignored_en", enable_sw, 4'b0001);
      check("glitch_ignored_idx", shape_idx, 2'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
